// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The verdict is one-hot {gt, eq, lt}; the all-zero code is the reset value.
package cmp_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  typedef logic [2:0] verdict_t;

  localparam verdict_t CMP_NONE = 3'b000;
  localparam verdict_t CMP_GT   = 3'b100;
  localparam verdict_t CMP_EQ   = 3'b010;
  localparam verdict_t CMP_LT   = 3'b001;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Combinational 1-bit decider: reports whether this x/y pair alone orders the operands.
module cmp_bit_cell (
  input  logic x,
  input  logic y,
  output logic bit_gt,
  output logic bit_lt
);

  assign bit_gt = x & ~y;
  assign bit_lt = ~x & y;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator producing one registered gt/eq/lt verdict per word.
// The first differing bit pair decides the word; later bits are only counted.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bit_valid,
  input  logic                          bit_first,
  input  logic                          x,
  input  logic                          y,
  output logic                          busy,
  output logic [count_width(WIDTH)-1:0] bit_count,
  output logic                          result_valid,
  output logic                          gt,
  output logic                          eq,
  output logic                          lt,
  output logic                          protocol_err
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  state_t        state_r;
  state_t        state_nx_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic          decided_r;
  logic          gt_int_r;
  logic          lt_int_r;
  logic          decided_nx_s;
  logic          gt_int_nx_s;
  logic          lt_int_nx_s;
  logic          base_decided_s;
  logic          base_gt_s;
  logic          base_lt_s;
  verdict_t      verdict_r;
  verdict_t      verdict_nx_s;
  logic          result_valid_r;
  logic          protocol_err_r;
  logic          start_s;
  logic          cont_s;
  logic          complete_s;
  logic          err_s;
  logic          bit_gt_s;
  logic          bit_lt_s;
  logic          busy_s;

  cmp_bit_cell u_bit_cell (
    .x      (x),
    .y      (y),
    .bit_gt (bit_gt_s),
    .bit_lt (bit_lt_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, count and per-bit evaluation; a bit_first accept always restarts the word
  always_comb begin
    start_s    = bit_valid & bit_first;
    cont_s     = bit_valid & ~bit_first & (state_r == COMPARE);
    err_s      = bit_valid & (bit_first ? (state_r == COMPARE) : (state_r == IDLE));
    count_nx_s = start_s ? CNT_ONE : (count_r + CNT_ONE);
    complete_s = (start_s | cont_s) && (count_nx_s == CNT_FULL);

    base_decided_s = start_s ? 1'b0 : decided_r;
    base_gt_s      = start_s ? 1'b0 : gt_int_r;
    base_lt_s      = start_s ? 1'b0 : lt_int_r;

    if (!base_decided_s) begin
      gt_int_nx_s  = bit_gt_s;
      lt_int_nx_s  = bit_lt_s;
      decided_nx_s = bit_gt_s | bit_lt_s;
    end else begin
      gt_int_nx_s  = base_gt_s;
      lt_int_nx_s  = base_lt_s;
      decided_nx_s = 1'b1;
    end

    verdict_nx_s = gt_int_nx_s ? CMP_GT : (lt_int_nx_s ? CMP_LT : CMP_EQ);

    case (state_r)
      IDLE: begin
        if (start_s && !complete_s) begin
          state_nx_s = COMPARE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      COMPARE: begin
        if (complete_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = COMPARE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    busy_s = (state_r == COMPARE);
  end

  // Counter, running verdict and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r        <= CNT_ZERO;
      decided_r      <= 1'b0;
      gt_int_r       <= 1'b0;
      lt_int_r       <= 1'b0;
      verdict_r      <= CMP_NONE;
      result_valid_r <= 1'b0;
      protocol_err_r <= 1'b0;
    end else begin
      result_valid_r <= complete_s;
      protocol_err_r <= err_s;
      if (complete_s) begin
        count_r   <= CNT_ZERO;
        decided_r <= 1'b0;
        gt_int_r  <= 1'b0;
        lt_int_r  <= 1'b0;
        verdict_r <= verdict_nx_s;
      end else if (start_s || cont_s) begin
        count_r   <= count_nx_s;
        decided_r <= decided_nx_s;
        gt_int_r  <= gt_int_nx_s;
        lt_int_r  <= lt_int_nx_s;
      end
    end
  end

  assign busy         = busy_s;
  assign bit_count    = count_r;
  assign result_valid = result_valid_r;
  assign gt           = verdict_r[2];
  assign eq           = verdict_r[1];
  assign lt           = verdict_r[0];
  assign protocol_err = protocol_err_r;

endmodule
